my_acc: RTL and testbench

- Sequential accumulation stage that sits directly downstream of the 32-bit adder (`my_add`).
- Consumes a frame of LEN operand words (adder results, each with its overflow flag) over a valid/ready handshake.
- Accumulates them modulo 2^BIT_WIDTH and tracks a sticky overflow.
- Presents the frame total on a held valid/ready output port.

---
 rtl/my_acc.sv | 86 ++++++++
 tb/tb_my_acc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/my_acc.sv
// my_acc: frame accumulator that sums LEN adder results modulo 2^BIT_WIDTH with a sticky overflow
module my_acc #(
    parameter int BIT_WIDTH   = 32,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] len,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIT_WIDTH-1:0]   in_data,
    input  logic                   in_ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIT_WIDTH-1:0]   out_sum,
    output logic                   out_ovf,
    output logic [COUNT_WIDTH-1:0] out_count
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [BIT_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [BIT_WIDTH:0]     sum;
    logic                   accept;

    // the extra top bit of sum is the carry out of the wrapping add
    assign sum    = {1'b0, acc_q} + {1'b0, in_data};
    assign accept = (state_q == ACC) && in_valid;

    // outputs decode from state and registers only, never from in_valid/out_ready
    assign busy      = state_q != IDLE;
    assign in_ready  = state_q == ACC;
    assign out_valid = state_q == HOLD;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

    // next-state: frame launch in IDLE, accumulate in ACC, release result from HOLD
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: if (start) begin
                acc_d       = '0;
                ovf_d       = 1'b0;
                count_d     = '0;
                remaining_d = len;
                state_d     = (len == '0) ? HOLD : ACC;
            end
            ACC: if (accept) begin
                acc_d       = sum[BIT_WIDTH-1:0];
                ovf_d       = ovf_q | sum[BIT_WIDTH] | in_ovf;
                count_d     = count_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == COUNT_WIDTH'(1)) ? HOLD : ACC;
            end
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
        end
    end
endmodule

// File: tb/tb_my_acc.sv
// tb_my_acc: randomized self-checking bench for my_acc against an arithmetic frame model
module tb_my_acc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_ovf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] ops[$];
    bit          ovfs[$];

    my_acc dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ovf(in_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result: wrapped total, overflow if any input flag or the unwrapped total exceeds 32 bits
    task automatic run_frame(input int hold_wait, input bit gaps, input bit poke);
        int n = ops.size();
        int idx = 0;
        int cyc = 0;
        bit fire;
        bit saw_ready = 0;
        longint unsigned total = 0;
        bit any = 0;
        logic [31:0] es;
        bit eo;
        foreach (ops[i]) begin
            total += 64'(ops[i]);
            any |= ovfs[i];
        end
        es = total[31:0];
        eo = any || ((total >> 32) != 0);
        @(negedge clk);
        start = 1'b1;
        len = n[7:0];
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (!out_valid && cyc < 4000) begin
            in_valid = (idx < n) && (!gaps || $urandom_range(0, 1) == 1);
            if (idx < n) begin
                in_data = ops[idx];
                in_ovf = ovfs[idx];
            end
            start = poke && ($urandom_range(0, 3) == 0);
            len = 8'($urandom);
            fire = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (fire) begin
                idx++;
                if (idx == n) check("valid_latency", out_valid, 1);
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (cyc >= 4000) check("frame_timeout", 0, 1);
        if (n == 0) saw_ready = in_ready;
        check("accepts", idx, n);
        check("sum", out_sum, es);
        check("ovf", out_ovf, eo);
        check("count", out_count, n);
        check("ready_in_hold", in_ready, 0);
        if (n == 0) check("empty_no_ready", saw_ready, 0);
        for (int h = 0; h < hold_wait; h++) begin
            start = poke && ($urandom_range(0, 1) == 1);
            len = 8'($urandom);
            in_valid = $urandom_range(0, 1) == 1;
            in_data = $urandom;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, es);
            check("hold_ovf", out_ovf, eo);
            check("hold_count", out_count, n);
        end
        in_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_falls", out_valid, 0);
        check("busy_falls", busy, 0);
        check("sum_kept", out_sum, es);
        check("ovf_kept", out_ovf, eo);
        check("count_kept", out_count, n);
    endtask

    task automatic set_ops(input int n, input bit rand_ovf);
        ops.delete();
        ovfs.delete();
        for (int i = 0; i < n; i++) begin
            ops.push_back($urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom);
            ovfs.push_back(rand_ovf && ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_count", out_count, 0);
        reset = 1'b0;
        start = 1'b0;

        ops = '{32'h1, 32'h2, 32'h3};
        ovfs = '{0, 0, 0};
        run_frame(0, 0, 0);

        ops = '{32'hFFFF_FFFF, 32'h1};
        ovfs = '{0, 0};
        run_frame(1, 0, 0);

        ops = '{32'h10, 32'h20};
        ovfs = '{1, 0};
        run_frame(0, 0, 0);

        ops.delete();
        ovfs.delete();
        run_frame(2, 0, 0);

        set_ops(4, 1);
        run_frame(5, 1, 1);

        // reset after two accepts of a five-word frame
        @(negedge clk);
        start = 1'b1;
        len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h1234;
        in_ovf = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_count", out_count, 0);
        ops = '{32'h7};
        ovfs = '{0};
        run_frame(0, 0, 0);

        set_ops(255, 1);
        run_frame(1, 0, 0);

        for (int f = 0; f < 12; f++) begin
            set_ops($urandom_range(0, 12), 1);
            run_frame($urandom_range(0, 4), 1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
